// File: rtl/well_grid.sv
// well_grid -- parametrised Tetris well with a locked-cell colour grid.
//
// Draws the gray walls and floor around a WELL_BLOCKS_COL x WELL_BLOCKS_ROW
// grid of locked-cell colours. It takes single-cell writes from the
// piece-lock logic and answers registered occupancy queries for collision
// checks. After the last cell of a piece it scans for full rows, collapses
// them and reports how many were removed.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   col, row          current pixel address
//   color             registered pixel colour (1 cycle after col/row)
//   wr_valid/wr_ready cell-write handshake (ready only while idle)
//   wr_x, wr_y        cell to write (0,0 = top-left)
//   wr_color          colour to store; EMPTY_COLOR clears the cell
//   wr_last           last cell of a piece, starts the row scan
//   q_x, q_y          occupancy query cell
//   q_occupied        registered occupancy (out of range reads as solid)
//   clear_done        one-cycle pulse at the end of a scan
//   lines_cleared     rows removed by the last scan, saturating at 7
//
// Optional feature: define WELL_GRID_GRIDLINES_EN to draw the top pixel row
// and left pixel column of each empty interior cell in WALL_COLOR.

package well_grid_pkg;
   typedef logic [3:0] color_t;
   localparam color_t BLACK   = 4'd0;
   localparam color_t BLUE    = 4'd1;
   localparam color_t GREEN   = 4'd2;
   localparam color_t CYAN    = 4'd3;
   localparam color_t RED     = 4'd4;
   localparam color_t MAGENTA = 4'd5;
   localparam color_t YELLOW  = 4'd6;
   localparam color_t WHITE   = 4'd7;
   localparam color_t GRAY    = 4'd8;
endpackage

module well_grid
   import well_grid_pkg::*;
#(
   parameter int     OFFSET_COL      = 100,
   parameter int     OFFSET_ROW      = 10,
   parameter int     BLOCK_SIZE      = 16,
   parameter int     WELL_BLOCKS_COL = 10,
   parameter int     WELL_BLOCKS_ROW = 20,
   parameter color_t WALL_COLOR      = GRAY,
   parameter color_t EMPTY_COLOR     = BLACK,
   localparam int    XW              = $clog2(WELL_BLOCKS_COL),
   localparam int    YW              = $clog2(WELL_BLOCKS_ROW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [10:0]   col,
   input  logic [10:0]   row,
   output color_t        color,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [XW-1:0] wr_x,
   input  logic [YW-1:0] wr_y,
   input  color_t        wr_color,
   input  logic          wr_last,
   input  logic [XW-1:0] q_x,
   input  logic [YW-1:0] q_y,
   output logic          q_occupied,
   output logic          clear_done,
   output logic [2:0]    lines_cleared
);

   localparam int LB    = $clog2(BLOCK_SIZE);
   localparam int C_END = OFFSET_COL + (WELL_BLOCKS_COL + 2) * BLOCK_SIZE;
   localparam int R_END = OFFSET_ROW + (WELL_BLOCKS_ROW + 1) * BLOCK_SIZE;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   color_t        r_grid     [WELL_BLOCKS_ROW][WELL_BLOCKS_COL];
   color_t        w_grid_nxt [WELL_BLOCKS_ROW][WELL_BLOCKS_COL];
   logic [1:0]    r_state;
   logic [YW-1:0] r_ptr_y;
   logic [YW-1:0] r_sh_y;
   logic [2:0]    r_count;
   color_t        r_color;
   logic          r_q_occ;

   logic          w_wr_fire;
   logic          w_wr_in;
   logic          w_q_in;
   logic          w_q_occ_nxt;
   logic          w_row_full;

   logic          w_in_wall;
   logic [10:0]   w_rel_c;
   logic [10:0]   w_rel_r;
   logic [10:0]   w_cx;
   logic [10:0]   w_cy;
   logic [XW-1:0] w_gx;
   logic [YW-1:0] w_gy;
   color_t        w_cell;
   logic          w_grid_line;
   color_t        w_pix;

   assign wr_ready      = (r_state == IDLE);
   assign clear_done    = (r_state == DONE);
   assign lines_cleared = r_count;
   assign color         = r_color;
   assign q_occupied    = r_q_occ;

   assign w_wr_fire = wr_valid && wr_ready;
   assign w_wr_in   = (32'(wr_x) < WELL_BLOCKS_COL) && (32'(wr_y) < WELL_BLOCKS_ROW);
   assign w_q_in    = (32'(q_x) < WELL_BLOCKS_COL) && (32'(q_y) < WELL_BLOCKS_ROW);

   // Next grid image: either one cell write (idle) or one row move (shift).
   // The query samples this image so it sees a write landing on the same edge.
   always_comb begin
      w_grid_nxt = r_grid;
      if (w_wr_fire && w_wr_in) begin
         w_grid_nxt[wr_y][wr_x] = wr_color;
      end
      if (r_state == SHIFT) begin
         if (r_sh_y != '0) begin
            w_grid_nxt[r_sh_y] = r_grid[r_sh_y - YW'(1)];
         end else begin
            for (int x = 0; x < WELL_BLOCKS_COL; x++) begin
               w_grid_nxt[0][XW'(x)] = EMPTY_COLOR;
            end
         end
      end
   end

   assign w_q_occ_nxt = w_q_in ? (w_grid_nxt[q_y][q_x] != EMPTY_COLOR) : 1'b1;

   always_comb begin
      w_row_full = 1'b1;
      for (int x = 0; x < WELL_BLOCKS_COL; x++) begin
         if (r_grid[r_ptr_y][XW'(x)] == EMPTY_COLOR) begin
            w_row_full = 1'b0;
         end
      end
   end

   // Pixel decode: cell coordinates relative to the left wall / well top.
   assign w_in_wall = (col >= 11'(OFFSET_COL)) && (col < 11'(C_END)) &&
                      (row >= 11'(OFFSET_ROW)) && (row < 11'(R_END));
   assign w_rel_c   = col - 11'(OFFSET_COL);
   assign w_rel_r   = row - 11'(OFFSET_ROW);
   assign w_cx      = w_rel_c >> LB;
   assign w_cy      = w_rel_r >> LB;
   // Cell column 0 is the left wall, so interior x is one less.
   assign w_gx      = XW'(w_cx - 11'd1);
   assign w_gy      = YW'(w_cy);
   assign w_cell    = r_grid[w_gy][w_gx];

`ifdef WELL_GRID_GRIDLINES_EN
   assign w_grid_line = (w_cell == EMPTY_COLOR) &&
                        ((w_rel_c[LB-1:0] == '0) || (w_rel_r[LB-1:0] == '0));
`else
   assign w_grid_line = 1'b0;
`endif

   always_comb begin
      w_pix = EMPTY_COLOR;
      if (w_in_wall) begin
         if ((w_cx == '0) || (w_cx == 11'(WELL_BLOCKS_COL + 1)) ||
             (w_cy == 11'(WELL_BLOCKS_ROW))) begin
            w_pix = WALL_COLOR;
         end else if (w_grid_line) begin
            w_pix = WALL_COLOR;
         end else begin
            w_pix = w_cell;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grid  <= '{default: '{default: EMPTY_COLOR}};
         r_color <= EMPTY_COLOR;
         r_q_occ <= 1'b0;
      end else begin
         r_grid  <= w_grid_nxt;
         r_color <= w_pix;
         r_q_occ <= w_q_occ_nxt;
      end
   end

   // Scan runs bottom-up; after a collapse the same row is rescanned since
   // it now holds what used to be the row above.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr_y <= '0;
         r_sh_y  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wr_fire && wr_last) begin
                  r_state <= SCAN;
                  r_ptr_y <= YW'(WELL_BLOCKS_ROW - 1);
                  r_count <= '0;
               end
            end
            SCAN: begin
               if (w_row_full) begin
                  r_state <= SHIFT;
                  r_sh_y  <= r_ptr_y;
                  if (r_count != 3'd7) begin
                     r_count <= r_count + 3'd1;
                  end
               end else if (r_ptr_y == '0) begin
                  r_state <= DONE;
               end else begin
                  r_ptr_y <= r_ptr_y - YW'(1);
               end
            end
            SHIFT: begin
               if (r_sh_y == '0) begin
                  r_state <= SCAN;
               end else begin
                  r_sh_y <= r_sh_y - YW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_well_grid.sv
`timescale 1ns/1ps
module tb_well_grid;
   import well_grid_pkg::*;

   localparam int XW = 4;
   localparam int YW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [10:0]   col = '0;
   logic [10:0]   row = '0;
   color_t        color;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [XW-1:0] wr_x = '0;
   logic [YW-1:0] wr_y = '0;
   color_t        wr_color = BLACK;
   logic          wr_last = 1'b0;
   logic [XW-1:0] q_x = '0;
   logic [YW-1:0] q_y = '0;
   logic          q_occupied;
   logic          clear_done;
   logic [2:0]    lines_cleared;

   well_grid dut (
      .clk(clk), .reset(reset), .col(col), .row(row), .color(color),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_color(wr_color), .wr_last(wr_last), .q_x(q_x), .q_y(q_y),
      .q_occupied(q_occupied), .clear_done(clear_done),
      .lines_cleared(lines_cleared)
   );

   always #5 clk = ~clk;

   typedef struct { int exp; string nm; } exp_t;
   typedef struct { int lines; int lat; string nm; } done_t;

   exp_t  px_q[$];
   exp_t  qo_q[$];
   done_t dn_q[$];
   exp_t  mon_e;
   done_t mon_d;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic px_req = 1'b0, q_req = 1'b0;
   logic px_vld_p1 = 1'b0, q_vld_p1 = 1'b0;

   task automatic check(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail(string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s", nm);
   endtask

   // Request tracking: a pixel/query issued before an edge is answered
   // after it; the accepting edge of a wr_last write starts the latency count.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      px_vld_p1 <= px_req;
      q_vld_p1  <= q_req;
      if (wr_valid && wr_ready && wr_last) acc_cyc <= cyc;
   end

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   always @(negedge clk) begin
      if (px_vld_p1) begin
         if (px_q.size() == 0) fail("pixel response with empty queue");
         else begin
            mon_e = px_q.pop_front();
            check(mon_e.nm, int'(color), mon_e.exp);
         end
      end
      if (q_vld_p1) begin
         if (qo_q.size() == 0) fail("query response with empty queue");
         else begin
            mon_e = qo_q.pop_front();
            check(mon_e.nm, int'(q_occupied), mon_e.exp);
         end
      end
      if (clear_done) begin
         if (dn_q.size() == 0) begin
            fail($sformatf("unexpected clear_done lines=%0d", lines_cleared));
         end else begin
            mon_d = dn_q.pop_front();
            check({mon_d.nm, " lines"}, int'(lines_cleared), mon_d.lines);
            check({mon_d.nm, " latency"}, cyc - acc_cyc, mon_d.lat);
         end
      end
   end

   task automatic wait_ready(string nm);
      int n = 0;
      while (!wr_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) fail({nm, " wr_ready timeout"});
   endtask

   task automatic do_write(int x, int y, color_t c, bit last);
      wait_ready("write");
      wr_x = XW'(x); wr_y = YW'(y); wr_color = c; wr_last = last;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic pix(int c, int r, int e, string nm);
      col = 11'(c); row = 11'(r); px_req = 1'b1;
      px_q.push_back(exp_t'{e, nm});
      @(negedge clk);
      px_req = 1'b0;
   endtask

   task automatic qry(int x, int y, int e, string nm);
      q_x = XW'(x); q_y = YW'(y); q_req = 1'b1;
      qo_q.push_back(exp_t'{e, nm});
      @(negedge clk);
      q_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset color", int'(color), int'(BLACK));
      check("reset q_occupied", int'(q_occupied), 0);
      check("reset clear_done", int'(clear_done), 0);
      check("reset lines_cleared", int'(lines_cleared), 0);
      check("reset wr_ready", int'(wr_ready), 1);

      // Frame geometry with an empty grid.
      pix(100, 10, GRAY, "px left wall top");
      pix(116, 10, BLACK, "px empty cell 0,0");
      pix(276, 330, GRAY, "px right floor corner");
      pix(99, 10, BLACK, "px left of wall");
      pix(292, 10, BLACK, "px right of wall");
      pix(291, 345, GRAY, "px last wall pixel");
      pix(116, 346, BLACK, "px below floor");
      qry(10, 0, 1, "q x out of range");
      qry(0, 20, 1, "q y out of range");
      qry(0, 0, 0, "q empty cell");

      // Single cell with wr_last, no full rows; a write held during the scan.
      dn_q.push_back(done_t'{0, 21, "single"});
      wait_ready("single");
      wr_x = 3; wr_y = 19; wr_color = RED; wr_last = 1'b1; wr_valid = 1'b1;
      q_x = 3; q_y = 19; q_req = 1'b1;
      qo_q.push_back(exp_t'{1, "q same-edge write"});
      @(negedge clk);
      wr_last = 1'b0; wr_x = 5; wr_y = 5; wr_color = GREEN;
      q_x = 5; q_y = 5;
      for (int i = 0; i < 100 && !wr_ready; i++) begin
         qo_q.push_back(exp_t'{0, "q held write"});
         @(negedge clk);
      end
      check("wr_ready returns", int'(wr_ready), 1);
      qo_q.push_back(exp_t'{1, "q held write accepted"});
      @(negedge clk);
      wr_valid = 1'b0; q_req = 1'b0;
      do_write(5, 5, BLACK, 0);
      qry(5, 5, 0, "q cleared cell");
      pix(164, 314, RED, "px cell 3,19 first");
      pix(179, 329, RED, "px cell 3,19 last");
      pix(180, 314, BLACK, "px cell 4,19");

      // One full row with a block sitting above it.
      do_write(0, 18, BLUE, 0);
      dn_q.push_back(done_t'{1, 42, "one row"});
      for (int x = 0; x < 10; x++) do_write(x, 19, RED, x == 9);
      wait_ready("one row");
      pix(116, 314, BLUE, "px dropped 0,19");
      qry(0, 19, 1, "q dropped 0,19");
      qry(3, 19, 0, "q row19 x3 cleared");
      qry(0, 18, 0, "q row18 empty");
      qry(0, 0, 0, "q row0 empty");

      // Rows 19 and 17 full, row 18 partial.
      for (int x = 1; x < 10; x++) do_write(x, 19, CYAN, 0);
      for (int x = 0; x < 5; x++) do_write(x, 18, GREEN, 0);
      dn_q.push_back(done_t'{2, 62, "two rows"});
      for (int x = 0; x < 10; x++) do_write(x, 17, YELLOW, x == 9);
      wait_ready("two rows");
      pix(116, 314, GREEN, "px partial 0,19");
      pix(180, 314, GREEN, "px partial 4,19");
      pix(196, 314, BLACK, "px partial 5,19");
      qry(4, 19, 1, "q partial 4,19");
      qry(5, 19, 0, "q partial 5,19");
      qry(0, 18, 0, "q row18 after");
      qry(9, 17, 0, "q row17 after");

      // Out-of-range write: dropped, but its wr_last still scans.
      dn_q.push_back(done_t'{0, 21, "oob last"});
      do_write(12, 3, MAGENTA, 1);
      wait_ready("oob last");
      qry(2, 3, 0, "q oob row3");
      qry(4, 19, 1, "q oob keeps grid");

      // Reset during SHIFT.
      for (int x = 5; x < 10; x++) do_write(x, 19, WHITE, x == 9);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid-shift reset wr_ready", int'(wr_ready), 1);
      check("mid-shift reset q_occupied", int'(q_occupied), 0);
      check("mid-shift reset lines", int'(lines_cleared), 0);
      check("mid-shift reset clear_done", int'(clear_done), 0);
      qry(4, 19, 0, "q after reset 4,19");
      qry(9, 19, 0, "q after reset 9,19");
      pix(116, 314, BLACK, "px after reset 0,19");
      repeat (60) @(negedge clk);

      check("done queue drained", dn_q.size(), 0);
      check("pixel queue drained", px_q.size(), 0);
      check("query queue drained", qo_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
